// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit MEM-stage port onto a 16-bit asynchronous SRAM
//
// Purpose: runs each 32-bit load/store as two 16-bit SRAM accesses (low half,
// then high half), each lasting WAIT_CYCLES cycles, and holds ready low until
// the access completes so the pipeline stays frozen.
//
// Ports:
//   clk, rst      system clock (rising edge), asynchronous active-high reset
//   rd_en, wr_en  MEM-stage load / store request (wr_en wins if both high)
//   address       byte address, word aligned; BASE_ADDR maps to SRAM word 0
//   write_data    store value
//   read_data     loaded word, registered, held until the next read
//   ready         high when no access is pending or the access completes now
//   sram_addr     half-word address to the SRAM
//   sram_we_n     SRAM write strobe, active low
//   sram_dq_out   data driven to the SRAM
//   sram_dq_oe    1 = controller drives the SRAM data bus
//   sram_dq_in    data returned by the SRAM

module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_we_n,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_in
);

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]             counter;
    logic [SRAM_ADDR_W-2:0] word_q;
    logic [31:0]            wdata_q;
    logic                   is_write_q;

    logic                   request;
    logic                   start;
    logic                   cnt_done;
    logic [31:0]            addr_off;
    logic [SRAM_ADDR_W-2:0] req_word;

    // Sources for the registered SRAM outputs: on the edge leaving IDLE the
    // latches are not loaded yet, so take the request inputs directly.
    logic [SRAM_ADDR_W-2:0] cur_word;
    logic [31:0]            cur_wdata;
    logic                   cur_write;

    logic                   unused_addr_bits;

    assign request  = rd_en | wr_en;
    assign start    = (state == IDLE) && request;
    assign cnt_done = (counter == 4'(WAIT_CYCLES - 1));
    assign addr_off = address - 32'(BASE_ADDR);
    assign req_word = addr_off[SRAM_ADDR_W:2];

    assign unused_addr_bits = ^{addr_off[31:SRAM_ADDR_W+1], addr_off[1:0]};

    assign cur_word  = start ? req_word   : word_q;
    assign cur_wdata = start ? write_data : wdata_q;
    assign cur_write = start ? wr_en      : is_write_q;

    assign ready = ((state == IDLE) && !request) || (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (request)  next_state = LO;
            LO:   if (cnt_done) next_state = HI;
            HI:   if (cnt_done) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            counter     <= 4'd0;
            word_q      <= '0;
            wdata_q     <= 32'd0;
            is_write_q  <= 1'b0;
            read_data   <= 32'd0;
            sram_addr   <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_dq_out <= 16'd0;
        end else begin
            if (start) begin
                word_q     <= req_word;
                wdata_q    <= write_data;
                is_write_q <= wr_en;
                counter    <= 4'd0;
            end else if (state == LO || state == HI) begin
                counter <= cnt_done ? 4'd0 : counter + 4'd1;
            end else begin
                counter <= 4'd0;
            end

            // The SRAM data has had the full WAIT_CYCLES to settle by the
            // last cycle of each half.
            if (!is_write_q && cnt_done) begin
                if (state == LO) read_data[15:0]  <= sram_dq_in;
                if (state == HI) read_data[31:16] <= sram_dq_in;
            end

            // Outputs are computed for the state being entered, so they are
            // flop outputs that change only on the clock edge.
            case (next_state)
                LO: begin
                    sram_addr   <= {cur_word, 1'b0};
                    sram_we_n   <= !cur_write;
                    sram_dq_oe  <= cur_write;
                    sram_dq_out <= cur_wdata[15:0];
                end
                HI: begin
                    sram_addr   <= {cur_word, 1'b1};
                    sram_we_n   <= !cur_write;
                    sram_dq_oe  <= cur_write;
                    sram_dq_out <= cur_wdata[31:16];
                end
                default: begin
                    sram_we_n  <= 1'b1;
                    sram_dq_oe <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - self-checking bench for sram_controller

module tb_sram_controller;

    localparam int WAIT = 2;
    localparam int LAT  = 1 + 2 * WAIT;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;

    logic [15:0] mem [0:255];
    logic [31:0] model [int];
    logic [31:0] exp_q [$];

    int checks  = 0;
    int errors  = 0;
    int strobes = 0;

    sram_controller #(
        .BASE_ADDR  (1024),
        .WAIT_CYCLES(WAIT),
        .SRAM_ADDR_W(18)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_we_n  (sram_we_n),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in)
    );

    always #5 clk = ~clk;

    assign sram_dq_in = mem[sram_addr[7:0]];

    always @(posedge clk) begin
        if (!sram_we_n) begin
            strobes = strobes + 1;
            if (sram_dq_oe) mem[sram_addr[7:0]] <= sram_dq_out;
        end
    end

    task automatic idle();
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    // Starts at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle
    // after DONE with the request inputs still driven.
    task automatic run_access(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        int          lat;
        bit          done;
        bit          saw_drive;
        int          idx;
        logic [31:0] e;
        idx        = int'((addr - 32'd1024) >> 2);
        wr_en      = wr;
        rd_en      = !wr;
        address    = addr;
        write_data = data;
        if (wr) model[idx] = data;
        else    exp_q.push_back(model.exists(idx) ? model[idx] : 32'd0);
        lat = 0;
        done = 1'b0;
        saw_drive = 1'b0;
        while (!done && lat < 100) begin
            @(negedge clk);
            if (!sram_we_n || sram_dq_oe) saw_drive = 1'b1;
            if (ready) done = 1'b1;
            else begin
                lat = lat + 1;
                @(posedge clk);
                #1;
            end
        end
        checks++;
        if (!done || lat != LAT) begin
            errors++;
            $display("FAIL latency addr=%0d: got %0d cycles (done=%0b), expected %0d", addr, lat, done, LAT);
        end
        if (!wr) begin
            checks++;
            if (saw_drive) begin
                errors++;
                $display("FAIL read_no_drive addr=%0d: we_n/oe asserted during a read", addr);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (read_data !== e) begin
                    errors++;
                    $display("FAIL read_data addr=%0d: got %h, expected %h", addr, read_data, e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        address = 32'd0;
        write_data = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (ready !== 1'b1)     begin errors++; $display("FAIL reset_ready: got %b, expected 1", ready); end
        checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b, expected 1", sram_we_n); end
        checks++; if (sram_dq_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b, expected 0", sram_dq_oe); end
        checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL reset_read_data: got %h, expected 0", read_data); end
        checks++; if (sram_addr !== 18'd0) begin errors++; $display("FAIL reset_sram_addr: got %h, expected 0", sram_addr); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_write();
        logic        e_ready;
        logic        e_we_n;
        logic [17:0] e_addr;
        logic [15:0] e_dq;
        wr_en      = 1'b1;
        address    = 32'd1024;
        write_data = 32'hDEADBEEF;
        model[0]   = 32'hDEADBEEF;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            e_ready = (c == 5);
            e_we_n  = !(c >= 1 && c <= 4);
            e_addr  = (c >= 3) ? 18'd1 : 18'd0;
            e_dq    = (c >= 3) ? 16'hDEAD : 16'hBEEF;
            checks++;
            if (ready !== e_ready) begin
                errors++; $display("FAIL write_ready cycle %0d: got %b, expected %b", c, ready, e_ready);
            end
            checks++;
            if (sram_we_n !== e_we_n || sram_dq_oe !== !e_we_n) begin
                errors++; $display("FAIL write_strobe cycle %0d: we_n=%b oe=%b, expected we_n=%b", c, sram_we_n, sram_dq_oe, e_we_n);
            end
            if (!e_we_n) begin
                checks++;
                if (sram_addr !== e_addr || sram_dq_out !== e_dq) begin
                    errors++; $display("FAIL write_bus cycle %0d: addr=%0d dq=%h, expected addr=%0d dq=%h", c, sram_addr, sram_dq_out, e_addr, e_dq);
                end
            end
            @(posedge clk);
            #1;
        end
        idle();
        checks++;
        if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD) begin
            errors++; $display("FAIL write_mem: got %h/%h, expected BEEF/DEAD", mem[0], mem[1]);
        end
    endtask

    task automatic test_read_back();
        run_access(1'b0, 32'd1024, 32'd0);
        idle();
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL read_idle_ready: got %b, expected 1", ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mapping();
        run_access(1'b1, 32'd1028, 32'h12345678);
        idle();
        checks++;
        if (mem[2] !== 16'h5678 || mem[3] !== 16'h1234) begin
            errors++; $display("FAIL map_mem: got %h/%h, expected 5678/1234", mem[2], mem[3]);
        end
        run_access(1'b0, 32'd1031, 32'd0);
        idle();
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 32'd1032, 32'hA5A55A5A);
        run_access(1'b0, 32'd1032, 32'd0);
        run_access(1'b0, 32'd1028, 32'd0);
        run_access(1'b0, 32'd1024, 32'd0);
        idle();
    endtask

    task automatic test_reset_mid();
        int s0;
        wr_en      = 1'b1;
        address    = 32'd1036;
        write_data = 32'hFFFF0000;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checks++;
        if (sram_we_n !== 1'b0 || sram_addr !== 18'd7) begin
            errors++; $display("FAIL mid_in_hi: we_n=%b addr=%0d, expected 0 and 7", sram_we_n, sram_addr);
        end
        #1;
        rst = 1'b1;
        idle();
        #1;
        checks++; if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin errors++; $display("FAIL mid_we_n: we_n=%b oe=%b, expected 1/0", sram_we_n, sram_dq_oe); end
        checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL mid_read_data: got %h, expected 0", read_data); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b, expected 1", ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        s0 = strobes;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checks++; if (strobes != s0) begin errors++; $display("FAIL mid_no_strobes: got %0d strobes, expected 0", strobes - s0); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %b, expected 1", ready); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_back();
        test_mapping();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Memory-side responder for the pipeline's MEM stage.
- Accepts one 32-bit read or write request from the MEM stage and runs it as two 16-bit accesses on an external asynchronous SRAM, each access lasting WAIT_CYCLES cycles.
- Holds `ready` low until the access completes. The top level uses `ready` to freeze every pipeline register.
- Replaces the single-cycle data memory inside MEM_stage.

Parameters:
- BASE_ADDR, 1024: byte address of data-memory word 0; subtracted before indexing.
- WAIT_CYCLES, 2: cycles per 16-bit SRAM access; legal range 1..15.
- SRAM_ADDR_W, 18: SRAM half-word address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_en  in  1  MEM-stage load request.
- wr_en  in  1  MEM-stage store request.
- address  in  32  byte address from the ALU result; word aligned.
- write_data  in  32  store value (Val_Rm).
- read_data  out  32  loaded word; registered.
- ready  out  1  high = no access pending, or access completing this cycle.
- sram_addr  out  SRAM_ADDR_W  half-word address.
- sram_we_n  out  1  SRAM write strobe, active low.
- sram_dq_out  out  16  data driven to the SRAM.
- sram_dq_oe  out  1  1 = controller drives the data bus.
- sram_dq_in  in  16  data returned by the SRAM.

Behaviour:
- Reset, asynchronous and active-high:
  - state=IDLE, counter=0, read_data=0, sram_addr=0, sram_we_n=1, sram_dq_oe=0, sram_dq_out=0.
  - ready takes its IDLE value.
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, using the low SRAM_ADDR_W-1 bits.
  - Low half at sram_addr = {word, 0}; high half at {word, 1}.
  - address[1:0] is ignored.
- States: IDLE, LO, HI, DONE.
- IDLE:
  - If rd_en or wr_en: latch address, write_data and the operation (write if wr_en; wr_en wins if both are high). Clear counter. Go to LO.
  - Otherwise stay in IDLE.
- LO:
  - sram_addr = {word, 0}.
  - Write: sram_we_n=0, sram_dq_oe=1, sram_dq_out=wdata[15:0].
  - Read: sram_we_n=1, sram_dq_oe=0.
  - Counter increments each cycle.
  - On the cycle counter == WAIT_CYCLES-1: a read captures sram_dq_in into read_data[15:0]; clear counter; go to HI.
- HI: same as LO, with half address 1, wdata[31:16], and the capture going into read_data[31:16]. Then go to DONE.
- DONE:
  - sram_we_n=1, sram_dq_oe=0.
  - Go to IDLE unconditionally. The pipeline advances on this clock edge.
- All SRAM-side outputs are registered and glitch free. sram_addr is stable for the full WAIT_CYCLES of each half.
- ready (combinational) = (state==IDLE and not (rd_en or wr_en)) or state==DONE.
- Latency: request seen in IDLE at cycle 0 → DONE at cycle 1+2·WAIT_CYCLES. ready is low for 1+2·WAIT_CYCLES cycles.
- read_data:
  - Valid from DONE onward.
  - Held until a later read's LO capture.
  - Writes do not modify it.
- Back-to-back requests: after DONE→IDLE, a request still asserted in IDLE starts a new access. ready drops in that same cycle. There is no idle bubble beyond that IDLE cycle.
- Requests arriving while in LO, HI or DONE are ignored; their inputs were latched in IDLE.
- Reset mid-access:
  - The state machine aborts immediately and sram_we_n rises asynchronously.
  - A partially written word in the SRAM is acceptable.
  - read_data returns to 0.

Test Plan:
- Reset: assert rst → ready=1 (no request), sram_we_n=1, sram_dq_oe=0, read_data=0, sram_addr=0.
- Write, WAIT_CYCLES=2: wr_en, address=1024, write_data=0xDEADBEEF →
  - cycles 1-2: sram_addr=0, we_n=0, dq_out=0xBEEF.
  - cycles 3-4: sram_addr=1, dq_out=0xDEAD.
  - ready low cycles 0-4, high cycle 5.
  - SRAM model holds 0xBEEF/0xDEAD.
- Read-back: rd_en, address=1024 → we_n stays 1, dq_oe=0; read_data=0xDEADBEEF at cycle 5; ready pulses high for one cycle.
- Mapping: write 0x12345678 at address 1028 → halves land at sram_addr 2 and 3. A read at 1031 returns 0x12345678 (low address bits ignored).
- Back-to-back: a write then a read with rd_en already high in the cycle after DONE → ready is high only in DONE, low again next cycle. The second access completes 5 cycles later with the correct data.
- Reset mid-access: assert rst during HI of a write → we_n=1 and state=IDLE immediately. After release with no request, ready=1 and there are no further SRAM strobes.
